uart_rx: RTL and testbench

Receive half of the board's serial link: deserialises 8N1 asynchronous frames arriving on the `RXD` pin into bytes and hands them to on-chip logic through a valid/ready handshake. It is the counterpart of `uart_tx` and sits between the `RXD` top-level input and the message-assembly logic that feeds `sha256`. Bit timing derives from the system clock by an integer divider. Glitch rejection, framing-error detection and overrun detection are built in.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial link (uart_rx / uart_tx).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin followed by a 3-sample majority vote.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_m
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Reset to the idle-line level so that no false start is seen after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign rx_s = sync_q[1];
  assign rx_m = majority3(hist_q);

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous receiver: samples mid-bit with an integer divider and hands bytes
// out through a single holding register with valid/ready, flagging framing errors and overruns.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 60000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  generate
    if (CPB < 8) begin : g_cpb_check
      $error("uart_rx: CLK_FREQ/BAUD must be at least 8 clocks per bit");
    end
  endgenerate

  logic rx_s;
  logic rx_m;

  uart_rx_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .rx_s (rx_s),
    .rx_m (rx_m)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_s_prev_q;
  logic                 commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s_prev_q && !rx_s) state_d = START;
      end
      START: begin
        // A start bit that is no longer low at its centre was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_m ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_m, shift_q[7:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_m) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_m) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A byte accepted on the commit cycle frees the register for the new one.
    if (commit) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      rx_s_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      rx_s_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx with an ideal bit-period line driver.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int CPB      = 16;
  // Pin edge -> rx_s low (2) -> stop sample (CPB/2 + 9*CPB) -> outputs visible (+1)
  localparam int LAT      = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         fe_cyc = -1;
  int         ov_cyc = -1;
  int         valid_rise_cyc = -1;
  int         last_start = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) begin
        if (fe_cnt == 0) fe_cyc = cyc;
        fe_cnt++;
      end
      if (overrun) begin
        if (ov_cnt == 0) ov_cyc = cyc;
        ov_cnt++;
      end
      if (valid && !valid_prev && valid_rise_cyc < 0) valid_rise_cyc = cyc;
    end
    valid_prev = valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    fe_cyc = -1;
    ov_cyc = -1;
    valid_rise_cyc = -1;
  endtask

  // Start bit, 8 data bits LSB first, then the given stop level; the stop bit's
  // last cycle is completed by the next call's leading clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    last_start = cyc;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      rx = b[i];
    end
    repeat (CPB) @(posedge clk); #1;
    rx = stop;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic line_idle(input int n);
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; ready = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle busy=%b valid=%b exp=0/0", busy, valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h61 : 8'($urandom);
      clear_obs();
      send_byte(b, 1'b1);
      line_idle(8);
      checks++; if (got_q.size() != 1 || got_q[0] !== b) begin
        failures++; $display("FAIL single_byte n=%0d first=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, b);
      end
      checks++; if (valid_rise_cyc != last_start + LAT) begin
        failures++; $display("FAIL single_latency got=%0d exp=%0d", valid_rise_cyc - last_start, LAT);
      end
      checks++; if (fe_cnt != 0 || ov_cnt != 0) begin
        failures++; $display("FAIL single_errors frame_err=%0d overrun=%0d exp=0/0", fe_cnt, ov_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'h61, 8'h62, 8'h63};
    for (int k = 0; k < 5; k++) exp_q.push_back(8'($urandom));
    ready = 1'b1;
    clear_obs();
    foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
    line_idle(8);
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++; if (fe_cnt != 0 || ov_cnt != 0) begin
      failures++; $display("FAIL b2b_errors frame_err=%0d overrun=%0d exp=0/0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    int c;
    ready = 1'b1;
    clear_obs();
    @(posedge clk); #1;
    c = cyc;
    rx = 1'b0;
    repeat (2) @(posedge clk); #1;
    rx = 1'b1;
    wait_cyc(c + 3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b exp=1", busy); end
    wait_cyc(c + 2 + 9);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall got=%b exp=0", busy); end
    line_idle(3 * CPB);
    checks++; if (got_q.size() != 0 || valid_rise_cyc >= 0 || fe_cnt != 0) begin
      failures++; $display("FAIL glitch_output bytes=%0d frame_err=%0d exp=0/0", got_q.size(), fe_cnt);
    end
  endtask

  task automatic test_frame_err();
    ready = 1'b1;
    clear_obs();
    send_byte(8'h55, 1'b0);
    line_idle(3 * CPB);
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
    checks++; if (fe_cyc != last_start + LAT) begin
      failures++; $display("FAIL ferr_timing got=%0d exp=%0d", fe_cyc - last_start, LAT);
    end
    checks++; if (got_q.size() != 0 || valid_rise_cyc >= 0) begin
      failures++; $display("FAIL ferr_valid bytes=%0d exp=0", got_q.size());
    end
    clear_obs();
    send_byte(8'hA5, 1'b1);
    line_idle(8);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      failures++; $display("FAIL ferr_recover n=%0d first=%h exp=a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    // Break: line held low far beyond one frame.
    clear_obs();
    send_byte(8'h00, 1'b0);
    repeat (6 * CPB) @(posedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy); end
    line_idle(3 * CPB);
    checks++; if (fe_cnt != 1 || got_q.size() != 0) begin
      failures++; $display("FAIL break_single_ferr frame_err=%0d bytes=%0d exp=1/0", fe_cnt, got_q.size());
    end
  endtask

  task automatic test_overrun();
    @(posedge clk); #1;
    ready = 1'b0;
    clear_obs();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    line_idle(8);
    checks++; if (valid !== 1'b1 || data !== 8'h11) begin
      failures++; $display("FAIL ovr_hold valid=%b data=%h exp=1/11", valid, data);
    end
    checks++; if (ov_cnt != 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end
    checks++; if (ov_cyc != last_start + LAT) begin
      failures++; $display("FAIL ovr_timing got=%0d exp=%0d", ov_cyc - last_start, LAT);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_release valid=%b exp=0", valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin
      failures++; $display("FAIL ovr_accept n=%0d first=%h exp=11", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_random_mix();
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] b;
    logic       stop;
    ready = 1'b1;
    clear_obs();
    exp_fe = 0;
    for (int k = 0; k < 10; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) exp_q.push_back(b);
      else exp_fe++;
      send_byte(b, stop);
      if (!stop) line_idle(CPB);
    end
    line_idle(8);
    checks++; if (fe_cnt != exp_fe || ov_cnt != 0) begin
      failures++; $display("FAIL rand_errors frame_err=%0d overrun=%0d exp=%0d/0", fe_cnt, ov_cnt, exp_fe);
    end
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ready = 1'b1;
    clear_obs();
    send_byte(8'h5A, 1'b1);
    line_idle(4);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL mid_reset data=%h valid=%b busy=%b ferr=%b ovr=%b exp=00/0/0/0/0",
                           data, valid, busy, frame_err, overrun);
    end
    reset = 1'b0;
    line_idle(3 * CPB);
    clear_obs();
    send_byte(8'h3C, 1'b1);
    line_idle(8);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C || fe_cnt != 0) begin
      failures++; $display("FAIL mid_recover n=%0d first=%h ferr=%0d exp=1/3c/0",
                           got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, fe_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_random_mix();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
